// File: rtl/sprite_pixel_writer.sv
// Streams sprite texels into VRAM: aligns the layer sequencer's address/valid with the
// sprite buffer read latency, drops colour-keyed or off-screen pixels and tracks pass end.
module sprite_pixel_writer #(
    parameter int                     VRAM_A_WIDTH      = 16,
    parameter int                     SPRITEBUF_A_WIDTH = 13,
    parameter int                     COLOR_WIDTH       = 12,
    parameter int                     SCREEN_WIDTH      = 320,
    parameter int                     SCREEN_HEIGHT     = 180,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_COLOR = 12'hF0F,
    parameter int                     SPRITE_RD_LATENCY = 2
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic [VRAM_A_WIDTH-1:0]      i_address_screen,
    input  logic [SPRITEBUF_A_WIDTH-1:0] i_address_s,
    input  logic                         i_is_layer_drawing,
    input  logic [COLOR_WIDTH-1:0]       i_sprite_data,
    output logic [SPRITEBUF_A_WIDTH-1:0] o_sprite_addr,
    output logic [VRAM_A_WIDTH-1:0]      o_vram_addr,
    output logic [COLOR_WIDTH-1:0]       o_vram_data,
    output logic                         o_vram_we,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic [16:0]                  o_wr_count,
    output logic [16:0]                  o_skip_count
);
    localparam int              L             = SPRITE_RD_LATENCY;
    localparam logic [31:0]     SCREEN_PIXELS = 32'(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam int              FW            = $clog2(L + 2);
    localparam logic [FW-1:0]   FLUSH_LOAD    = FW'(L + 1);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH} state_t;

    state_t                          state, state_nxt;
    logic [FW-1:0]                   flush_cnt, flush_cnt_nxt;
    logic                            frame_done_nxt, cnt_clr;
    logic [L-1:0]                    vld_pipe;
    logic [L-1:0][VRAM_A_WIDTH-1:0]  addr_pipe;
    logic                            vld_al, in_range, opaque, wr_hit, skip_hit;
    logic [VRAM_A_WIDTH-1:0]         addr_al;

    assign o_sprite_addr = i_address_s;

    // Delay line matching the sprite buffer read latency
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[0]  <= i_is_layer_drawing;
            addr_pipe[0] <= i_address_screen;
            for (int i = 1; i < L; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign vld_al   = vld_pipe[L-1];
    assign addr_al  = addr_pipe[L-1];
    assign in_range = 32'(addr_al) < SCREEN_PIXELS;
    assign opaque   = i_sprite_data != TRANSPARENT_COLOR;
    assign wr_hit   = vld_al & opaque & in_range;
    assign skip_hit = vld_al & ~wr_hit;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            o_vram_we   <= 1'b0;
            o_vram_addr <= '0;
            o_vram_data <= '0;
        end else begin
            o_vram_we <= wr_hit;
            if (wr_hit) begin
                o_vram_addr <= addr_al;
                o_vram_data <= i_sprite_data;
            end
        end
    end

    // Clear only happens from IDLE, where the delay line is already drained
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            o_wr_count   <= '0;
            o_skip_count <= '0;
        end else if (cnt_clr) begin
            o_wr_count   <= '0;
            o_skip_count <= '0;
        end else begin
            if (wr_hit && o_wr_count != '1)
                o_wr_count <= o_wr_count + 17'd1;
            if (skip_hit && o_skip_count != '1)
                o_skip_count <= o_skip_count + 17'd1;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            flush_cnt    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            flush_cnt    <= flush_cnt_nxt;
            o_frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = flush_cnt;
        frame_done_nxt = 1'b0;
        cnt_clr        = 1'b0;
        case (state)
            IDLE: if (i_is_layer_drawing) begin
                state_nxt = DRAW;
                cnt_clr   = 1'b1;
            end
            DRAW: if (!i_is_layer_drawing) begin
                state_nxt     = FLUSH;
                flush_cnt_nxt = FLUSH_LOAD;
            end
            FLUSH: begin
                if (i_is_layer_drawing) begin
                    state_nxt = DRAW;
                end else begin
                    flush_cnt_nxt = flush_cnt - 1'b1;
                    // Counter reaches zero on this edge: pass fully drained
                    if (flush_cnt == FW'(1)) begin
                        state_nxt      = IDLE;
                        frame_done_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = state != IDLE;
endmodule

// File: tb/tb_sprite_pixel_writer.sv
// Directed bench: writes scoreboarded through a queue and checked by a negedge monitor;
// counters and frame_done timing checked against hand-computed values.
module tb_sprite_pixel_writer;
    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i_address_screen = '0;
    logic [12:0] i_address_s = '0;
    logic        i_is_layer_drawing = 1'b0;
    logic [11:0] i_sprite_data;
    logic [12:0] o_sprite_addr;
    logic [15:0] o_vram_addr;
    logic [11:0] o_vram_data;
    logic        o_vram_we, o_busy, o_frame_done;
    logic [16:0] o_wr_count, o_skip_count;

    sprite_pixel_writer dut (
        .CLK(CLK), .rst(rst),
        .i_address_screen(i_address_screen), .i_address_s(i_address_s),
        .i_is_layer_drawing(i_is_layer_drawing), .i_sprite_data(i_sprite_data),
        .o_sprite_addr(o_sprite_addr), .o_vram_addr(o_vram_addr), .o_vram_data(o_vram_data),
        .o_vram_we(o_vram_we), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_wr_count(o_wr_count), .o_skip_count(o_skip_count)
    );

    always #5 CLK = ~CLK;

    // Sprite buffer model with 2-cycle read latency
    logic [11:0] mem [0:8191];
    logic [11:0] rd_p0 = '0, rd_p1 = '0;
    always @(posedge CLK) begin
        rd_p0 <= mem[o_sprite_addr];
        rd_p1 <= rd_p0;
    end
    assign i_sprite_data = rd_p1;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } exp_t;
    exp_t q[$];
    int checks = 0, failures = 0;
    int fd_cnt = 0, fd_cyc = -1;
    int idx = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every write must match the oldest expected write, at its exact cycle
    always @(negedge CLK) begin
        if (o_vram_we) begin
            if (q.size() == 0) begin
                check("unexpected_write", int'(o_vram_addr), -1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wr_addr", int'(o_vram_addr), e.addr);
                check("wr_data", int'(o_vram_data), e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (o_frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            check("busy_with_done", int'(o_busy), 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pix(input int addr, input int data, input bit writes);
        idx++;
        mem[idx] = 12'(data);
        i_address_s = 13'(idx);
        i_address_screen = 16'(addr);
        i_is_layer_drawing = 1'b1;
        #1;
        check("sprite_addr", int'(o_sprite_addr), idx);
        if (writes) q.push_back('{addr, data, cyc + 3});
        tick();
    endtask

    // Deassert drawing, drain, and check frame_done lands 4 cycles after the deassert cycle
    task automatic end_pass(input string name);
        int k, fd0;
        k = cyc;
        fd0 = fd_cnt;
        i_is_layer_drawing = 1'b0;
        repeat (8) tick();
        check({name, "_fd_count"}, fd_cnt - fd0, 1);
        check({name, "_fd_cycle"}, fd_cyc, k + 4);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_we", int'(o_vram_we), 0);
        check("rst_addr", int'(o_vram_addr), 0);
        check("rst_data", int'(o_vram_data), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_frame_done), 0);
        check("rst_wr", int'(o_wr_count), 0);
        check("rst_skip", int'(o_skip_count), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Single pixel, latency 3
        pix(100, 'h123, 1);
        end_pass("t1");
        check("t1_wr", int'(o_wr_count), 1);
        check("t1_skip", int'(o_skip_count), 0);

        // Transparency at positions 1 and 3
        pix(10, 'hABC, 1);
        pix(11, 'hF0F, 0);
        pix(12, 'h456, 1);
        pix(13, 'hF0F, 0);
        end_pass("t2");
        check("t2_wr", int'(o_wr_count), 2);
        check("t2_skip", int'(o_skip_count), 2);

        // Screen bounds
        pix(57599, 'h007, 1);
        pix(57600, 'h008, 0);
        end_pass("t3");
        check("t3_wr", int'(o_wr_count), 1);
        check("t3_skip", int'(o_skip_count), 1);

        // Ten pixels then pass end
        for (int i = 0; i < 10; i++) pix(200 + i, i + 1, 1);
        end_pass("t4");
        check("t4_wr", int'(o_wr_count), 10);
        check("t4_skip", int'(o_skip_count), 0);

        // One-cycle gap: FLUSH returns to DRAW, counters keep running
        pix(300, 'h001, 1);
        pix(301, 'h002, 1);
        pix(302, 'hF0F, 0);
        i_is_layer_drawing = 1'b0;
        tick();
        check("t5_busy_gap", int'(o_busy), 1);
        pix(303, 'h004, 1);
        pix(304, 'h005, 1);
        pix(305, 'h006, 1);
        end_pass("t5");
        check("t5_wr", int'(o_wr_count), 5);
        check("t5_skip", int'(o_skip_count), 1);

        // Reset with pixels in flight
        pix(400, 'h0AA, 1);
        pix(401, 'h0BB, 1);
        i_is_layer_drawing = 1'b0;
        tick();
        check("t6_we_before", int'(o_vram_we), 1);
        rst = 1'b1;
        q.delete();
        #1;
        check("t6_we", int'(o_vram_we), 0);
        check("t6_addr", int'(o_vram_addr), 0);
        check("t6_data", int'(o_vram_data), 0);
        check("t6_wr", int'(o_wr_count), 0);
        check("t6_busy", int'(o_busy), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        check("t6_wr_after", int'(o_wr_count), 0);
        check("t6_skip_after", int'(o_skip_count), 0);

        // First pass after reset
        pix(5, 'h321, 1);
        end_pass("t7");
        check("t7_wr", int'(o_wr_count), 1);

        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
